// File: rtl/token_decoder_if.sv
// Token-in / character-out handshake bundle for token_decoder.
//   tok_valid/tok_ready/tok_id : token ID offered by the producer
//   ch_valid/ch_ready          : character beat handshake toward the sink
//   ch_data/ch_last            : character payload and end-of-word flag
// master = producer/sink side, slave = decoder side.
interface token_decoder_if #(
   parameter int unsigned TOKEN_WIDTH = 4,
   parameter int unsigned DATA_WIDTH  = 8
);
   logic                   tok_valid;
   logic                   tok_ready;
   logic [TOKEN_WIDTH-1:0] tok_id;
   logic                   ch_valid;
   logic                   ch_ready;
   logic [DATA_WIDTH-1:0]  ch_data;
   logic                   ch_last;

   modport master (
      output tok_valid, tok_id, ch_ready,
      input  tok_ready, ch_valid, ch_data, ch_last
   );

   modport slave (
      input  tok_valid, tok_id, ch_ready,
      output tok_ready, ch_valid, ch_data, ch_last
   );
endinterface

// File: rtl/token_decoder.sv
// Detokenizer: takes one token ID, scans the vocab SRAM (null-terminated words
// packed from address 0) for the k-th word and streams its characters,
// terminator included, as valid/ready beats.
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (slave)      : token handshake in, character stream out
//   vocab_cs/addr    : vocab SRAM read strobe and address (data one cycle later)
//   vocab_dout       : vocab SRAM read data
//   err              : one-cycle pulse, word not found or runs off end of memory
//   busy             : high whenever not idle
module token_decoder #(
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned TOKEN_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   token_decoder_if.slave        bus,
   output logic                  vocab_cs,
   output logic [ADDR_WIDTH-1:0] vocab_addr,
   input  logic [DATA_WIDTH-1:0] vocab_dout,
   output logic                  err,
   output logic                  busy
);
   localparam int unsigned CNT_WIDTH = TOKEN_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

   // State bits double as registered outputs:
   // [0] tok_ready, [1] busy, [2] vocab_cs, [3] ch_valid, [4] emit phase
   typedef enum logic [4:0] {
      IDLE     = 5'b00001,
      SEEK_RD  = 5'b00110,
      SEEK_CHK = 5'b00010,
      EMIT_RD  = 5'b10110,
      EMIT_CHK = 5'b10010,
      EMIT_OUT = 5'b11010
   } state_t;

   state_t                  state;
   logic [TOKEN_WIDTH-1:0]  id;
   logic [CNT_WIDTH-1:0]    cnt;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH-1:0]   ch_data_q;
   logic                    ch_last_q;

   logic                    at_end;
   logic [CNT_WIDTH-1:0]    cnt_inc;

   assign at_end  = (addr == ADDR_MAX);
   assign cnt_inc = cnt + CNT_WIDTH'(1);

   assign bus.tok_ready = state[0];
   assign busy          = state[1];
   assign vocab_cs      = state[2];
   assign bus.ch_valid  = state[3];
   assign bus.ch_data   = ch_data_q;
   assign bus.ch_last   = ch_last_q;
   assign vocab_addr    = addr;

   // Seek/emit sequencer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         id        <= '0;
         cnt       <= '0;
         addr      <= '0;
         ch_data_q <= '0;
         ch_last_q <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.tok_valid) begin
                  id    <= bus.tok_id;
                  cnt   <= '0;
                  addr  <= '0;
                  state <= (bus.tok_id == '0) ? EMIT_RD : SEEK_RD;
               end
            end

            SEEK_RD: state <= SEEK_CHK;

            // Count terminators; the word starts right after the id-th one
            SEEK_CHK: begin
               if (vocab_dout != '0) begin
                  if (at_end) begin
                     err   <= 1'b1;
                     state <= IDLE;
                  end else begin
                     addr  <= addr + ADDR_WIDTH'(1);
                     state <= SEEK_RD;
                  end
               end else if (cnt_inc == {1'b0, id}) begin
                  if (at_end) begin
                     err   <= 1'b1;
                     state <= IDLE;
                  end else begin
                     addr  <= addr + ADDR_WIDTH'(1);
                     state <= EMIT_RD;
                  end
               end else begin
                  cnt <= cnt_inc;
                  if (at_end) begin
                     err   <= 1'b1;
                     state <= IDLE;
                  end else begin
                     addr  <= addr + ADDR_WIDTH'(1);
                     state <= SEEK_RD;
                  end
               end
            end

            EMIT_RD: state <= EMIT_CHK;

            // Last beat is the terminator, or the final address if memory ends first
            EMIT_CHK: begin
               ch_data_q <= vocab_dout;
               ch_last_q <= (vocab_dout == '0) || at_end;
               state     <= EMIT_OUT;
            end

            EMIT_OUT: begin
               if (bus.ch_ready) begin
                  if (ch_data_q == '0) begin
                     state <= IDLE;
                  end else if (at_end) begin
                     err   <= 1'b1;
                     state <= IDLE;
                  end else begin
                     addr  <= addr + ADDR_WIDTH'(1);
                     state <= EMIT_RD;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_token_decoder.sv
// Directed bench for token_decoder with a registered-read vocab SRAM model.
module tb_token_decoder;
   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned TW = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          vocab_cs;
   logic [AW-1:0] vocab_addr;
   logic [DW-1:0] vocab_dout = '0;
   logic          err;
   logic          busy;

   logic [DW-1:0] mem [16];

   int n_checks  = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int tok_cyc   = -1;
   int err_cnt   = 0;
   int err_cyc   = -1;
   int valid_cnt = 0;
   int beat_cyc  [$];
   logic [DW-1:0] beat_data [$];
   logic          beat_last [$];

   token_decoder_if #(.TOKEN_WIDTH(TW), .DATA_WIDTH(DW)) bus ();

   token_decoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TOKEN_WIDTH(TW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .vocab_cs   (vocab_cs),
      .vocab_addr (vocab_addr),
      .vocab_dout (vocab_dout),
      .err        (err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (vocab_cs) vocab_dout <= mem[vocab_addr];

   // Log handshakes and pulses mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.tok_valid && bus.tok_ready) tok_cyc = cyc;
         if (bus.ch_valid) valid_cnt++;
         if (bus.ch_valid && bus.ch_ready) begin
            beat_cyc.push_back(cyc);
            beat_data.push_back(bus.ch_data);
            beat_last.push_back(bus.ch_last);
         end
         if (err) begin
            err_cnt++;
            err_cyc = cyc;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      beat_cyc.delete();
      beat_data.delete();
      beat_last.delete();
      err_cnt   = 0;
      err_cyc   = -1;
      valid_cnt = 0;
   endtask

   task automatic load_vocab_a();
      for (int i = 0; i < 16; i++) mem[i] = '0;
      mem[0] = "h"; mem[1] = "i"; mem[2] = 8'h00;
      mem[3] = "o"; mem[4] = "k"; mem[5] = 8'h00;
      mem[6] = "a"; mem[7] = 8'h00;
   endtask

   task automatic load_vocab_b();
      mem[0]  = "a"; mem[1]  = 8'h00; mem[2]  = "b"; mem[3]  = 8'h00;
      mem[4]  = "c"; mem[5]  = "d";   mem[6]  = "e"; mem[7]  = "f";
      mem[8]  = "g"; mem[9]  = "h";   mem[10] = "i"; mem[11] = 8'h00;
      mem[12] = "W"; mem[13] = "X";   mem[14] = "Y"; mem[15] = "Z";
   endtask

   task automatic send_token(input logic [TW-1:0] k, output int t);
      @(posedge clk); #1;
      bus.tok_valid = 1'b1;
      bus.tok_id    = k;
      @(posedge clk); #1;
      bus.tok_valid = 1'b0;
      t = tok_cyc;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk); #1;
      end
   endtask

   // Returns the first cycle with tok_ready high, -1 on timeout
   task automatic wait_idle(output int c);
      c = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.tok_ready) begin
            c = cyc;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic check_beat(input string tag, input int i, input int t, input int off,
                             input logic [DW-1:0] d, input logic l);
      if (beat_cyc.size() <= i) begin
         check({tag, "_count"}, beat_cyc.size(), i + 1);
         return;
      end
      check({tag, "_cyc"},  beat_cyc[i] - t, off);
      check({tag, "_data"}, beat_data[i], d);
      check({tag, "_last"}, beat_last[i], l);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      int t;
      int idle;

      bus.tok_valid = 1'b0;
      bus.tok_id    = '0;
      bus.ch_ready  = 1'b1;
      load_vocab_a();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_tok_ready",  bus.tok_ready, 1);
      check("rst_ch_valid",   bus.ch_valid, 0);
      check("rst_ch_data",    bus.ch_data, 0);
      check("rst_ch_last",    bus.ch_last, 0);
      check("rst_vocab_cs",   vocab_cs, 0);
      check("rst_vocab_addr", vocab_addr, 0);
      check("rst_err",        err, 0);
      check("rst_busy",       busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Token 0: word at address 0
      clear_log();
      send_token(4'd0, t);
      wait_idle(idle);
      check("t0_beats", beat_cyc.size(), 3);
      check_beat("t0_b0", 0, t, 3, "h", 1'b0);
      check_beat("t0_b1", 1, t, 6, "i", 1'b0);
      check_beat("t0_b2", 2, t, 9, 8'h00, 1'b1);
      check("t0_idle", idle - t, 10);
      check("t0_err",  err_cnt, 0);

      // Token 1: seek over 3 bytes
      clear_log();
      send_token(4'd1, t);
      wait_idle(idle);
      check("t1_beats", beat_cyc.size(), 3);
      check_beat("t1_b0", 0, t, 9,  "o", 1'b0);
      check_beat("t1_b1", 1, t, 12, "k", 1'b0);
      check_beat("t1_b2", 2, t, 15, 8'h00, 1'b1);
      check("t1_idle", idle - t, 16);
      check("t1_err",  err_cnt, 0);

      // Token 12: only 11 terminators exist, scan runs to the end
      clear_log();
      send_token(4'd12, t);
      wait_idle(idle);
      check("t12_err_cnt", err_cnt, 1);
      check("t12_err_cyc", err_cyc - t, 33);
      check("t12_valid",   valid_cnt, 0);
      check("t12_idle",    idle - t, 33);

      // Word running off the end of memory
      load_vocab_b();
      clear_log();
      send_token(4'd3, t);
      wait_idle(idle);
      check("trunc_beats", beat_cyc.size(), 4);
      check_beat("trunc_b0", 0, t, 27, "W", 1'b0);
      check_beat("trunc_b1", 1, t, 30, "X", 1'b0);
      check_beat("trunc_b2", 2, t, 33, "Y", 1'b0);
      check_beat("trunc_b3", 3, t, 36, "Z", 1'b1);
      check("trunc_err_cnt", err_cnt, 1);
      check("trunc_err_cyc", err_cyc - t, 37);
      check("trunc_idle",    idle - t, 37);

      // Back-pressure on 'k' with a stray token offered meanwhile
      load_vocab_a();
      clear_log();
      send_token(4'd1, t);
      wait_cyc(t + 10);
      bus.ch_ready = 1'b0;
      wait_cyc(t + 12);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_valid", bus.ch_valid, 1);
         check("stall_data",  bus.ch_data, "k");
         check("stall_last",  bus.ch_last, 0);
         @(posedge clk); #1;
         if (k == 0) begin
            bus.tok_valid = 1'b1;
            bus.tok_id    = 4'd2;
         end else if (k == 1) begin
            bus.tok_valid = 1'b0;
         end
      end
      bus.ch_ready = 1'b1;
      wait_idle(idle);
      check("stall_beats", beat_cyc.size(), 3);
      check_beat("stall_b0", 0, t, 9,  "o", 1'b0);
      check_beat("stall_b1", 1, t, 17, "k", 1'b0);
      check_beat("stall_b2", 2, t, 20, 8'h00, 1'b1);
      check("stall_idle", idle - t, 21);
      repeat (3) @(posedge clk);
      #1;
      check("stall_no_restart", busy, 0);
      check("stall_err", err_cnt, 0);

      // Asynchronous reset while presenting 'o'
      clear_log();
      bus.ch_ready = 1'b0;
      send_token(4'd1, t);
      wait_cyc(t + 9);
      check("arst_pre_valid", bus.ch_valid, 1);
      check("arst_pre_data",  bus.ch_data, "o");
      #1 rst_n = 1'b0;
      #1;
      check("arst_valid",     bus.ch_valid, 0);
      check("arst_busy",      busy, 0);
      check("arst_cs",        vocab_cs, 0);
      check("arst_tok_ready", bus.tok_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      bus.ch_ready = 1'b1;
      clear_log();
      send_token(4'd2, t);
      wait_idle(idle);
      check("arst_beats", beat_cyc.size(), 2);
      check_beat("arst_b0", 0, t, 15, "a", 1'b0);
      check_beat("arst_b1", 1, t, 18, 8'h00, 1'b1);
      check("arst_idle", idle - t, 19);
      check("arst_err",  err_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/token_decoder.md
# token_decoder

Detokenizer for the tensor_core text path and the inverse of the encoder. It accepts one token ID per handshake and locates the matching word in the vocabulary SRAM, where words are stored as null-terminated strings packed from address 0. It then streams that word's characters, terminator included, on a valid/ready character port. It sits between the token producer (core output) and the character sink, and drives the read port of its own vocab sram instance.

## Interface
- ADDR_WIDTH, 4, vocab SRAM address width; the last address is 2^ADDR_WIDTH-1
- DATA_WIDTH, 8, character width
- TOKEN_WIDTH, 4, token ID width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- tok_valid  in  1  token ID offered
- tok_ready  out  1  high only in IDLE
- tok_id  in  TOKEN_WIDTH  token index k, 0-based word number in the vocab
- vocab_cs  out  1  vocab read strobe
- vocab_addr  out  ADDR_WIDTH  vocab read address
- vocab_dout  in  DATA_WIDTH  read data, valid the cycle after vocab_cs/vocab_addr
- ch_valid  out  1  character beat valid
- ch_ready  in  1  sink accepts beat
- ch_data  out  DATA_WIDTH  character; 0 on the terminator beat
- ch_last  out  1  final beat of the word
- err  out  1  one-cycle pulse: word not found, or word runs off the end of memory
- busy  out  1  high whenever the state is not IDLE

## Operation
- Registers:
  - state
  - id (TOKEN_WIDTH)
  - cnt, terminators seen (TOKEN_WIDTH+1)
  - addr (ADDR_WIDTH)
  - ch_data/ch_last
- The vocab layout is word0,0,word1,0,... Consecutive zeros are empty words and count as words.
- IDLE:
  - tok_ready=1.
  - On tok_valid, latch id and clear cnt and addr.
  - If id==0, go to EMIT_RD; otherwise go to SEEK_RD.
- SEEK_RD: vocab_cs=1 at addr, then go to SEEK_CHK.
- SEEK_CHK (dout is for addr):
  - dout!=0 and addr!=max: addr+1, go to SEEK_RD.
  - dout==0 and cnt+1==id:
    - If addr==max, err pulse, go to IDLE.
    - Else addr+1, go to EMIT_RD.
  - dout==0 and cnt+1!=id: cnt+1; then if addr==max, err pulse and go to IDLE; else addr+1 and go to SEEK_RD.
  - dout!=0 and addr==max: err pulse, go to IDLE.
- EMIT_RD: vocab_cs=1 at addr, then go to EMIT_CHK.
- EMIT_CHK: register ch_data=dout and ch_last=(dout==0 || addr==max), then go to EMIT_OUT.
- EMIT_OUT: ch_valid=1, with ch_data/ch_last held stable until ch_ready. On handshake:
  - ch_data==0: go to IDLE.
  - ch_data!=0 and addr==max: err pulse, go to IDLE. The word is truncated; ch_last was already 1.
  - Otherwise addr+1, go to EMIT_RD.
- vocab_cs is 0 in all other states. vocab_addr=addr at all times.
- tok_valid outside IDLE is ignored; it is not latched.
- cnt is one bit wider than id, so it never wraps before addr does.

## Timing
- Reset values:
  - state=IDLE, so tok_ready=1
  - ch_valid=0, ch_data=0, ch_last=0
  - vocab_cs=0, vocab_addr=0
  - err=0, busy=0
- Reset is asynchronous: assertion mid-seek or mid-emit drops ch_valid/vocab_cs immediately. No partial word resumes after reset.
- The token handshake occurs in cycle T. The word starts at address S. The first ch_valid rises at T+3+2S, since the seek costs 2 cycles per scanned byte.
- After a character handshake in cycle U, the next ch_valid rises at U+3. The minimum beat spacing is 3 cycles.
- tok_ready returns to 1 the cycle after the terminator handshake, and the cycle after any err pulse.
- err is high for exactly one cycle, in the cycle following the SEEK_CHK or EMIT_OUT that detected it. No ch_valid is asserted for a not-found token.
- ch_valid never depends combinationally on ch_ready.

## Test plan
- Vocab "h i 0 o k 0 a 0", addresses 8..15 = 0, token 0 handshake at T, ch_ready=1 -> beats 'h'@T+3, 'i'@T+6, 0 with ch_last@T+9; tok_ready=1 at T+10.
- Same vocab, token 1 -> first 'o' at T+9 (S=3), then 'k', then 0 with ch_last. err stays 0.
- Same vocab, token 12 (only 11 terminators exist) -> scan through address 15, a single err pulse, no ch_valid, then IDLE.
- Vocab with no zero at addresses 12..15 and token 3 starting at 12 -> beats at 12..15 with ch_last on 15, err pulse after that handshake.
- Token 1 with ch_ready held low for 5 cycles on 'k' -> ch_data='k' and ch_valid stable throughout; tok_valid pulsed meanwhile is ignored; the stream completes normally.
- rst_n asserted while in EMIT_OUT on 'o' -> ch_valid=0 and busy=0 immediately. After release, token 2 yields 'a', 0 correctly.
